// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution accumulator.
// Holds the FSM state type, default geometry and the saturation helper.
package conv_pkg;

    typedef enum logic {
        ACC,
        EMIT
    } state_t;

    localparam int KERNEL_SIZE = 3;
    localparam int PIC_SIZE    = 28;
    localparam int TAPS        = KERNEL_SIZE * KERNEL_SIZE;
    localparam int OUT_DIM     = PIC_SIZE - KERNEL_SIZE + 1;

    // Clamp a wide value into the w-bit signed or unsigned range.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input bit                 sgn,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = sgn ? (64'sd1 <<< (w - 1)) - 64'sd1
                 : (64'sd1 <<< w) - 64'sd1;
        lo = sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_accumulator_sat_round.sv
// Post-accumulation arithmetic: bias add, rounding shift,
// optional ReLU and saturation down to the pixel width.
module conv_sat_round
    import conv_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 13,
    parameter int SIGN      = 1,
    parameter int OUT_SHIFT = 0,
    parameter int RELU      = 1
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]     bias,
    output logic [WIDTH-1:0]     pix
);

    localparam int   SW = ACC_WIDTH + 2;
    localparam logic SX = (SIGN != 0);

    logic signed [SW-1:0] a_ext;
    logic signed [SW-1:0] b_ext;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shr;
    logic signed [63:0]   wide;

    assign a_ext = {{2{SX & acc[ACC_WIDTH-1]}}, acc};
    assign b_ext = {{(SW-WIDTH){SX & bias[WIDTH-1]}}, bias};
    assign sum   = a_ext + b_ext;

    if (OUT_SHIFT > 0) begin : g_rnd
        localparam logic signed [SW-1:0] HALF =
            SW'(64'd1 << (OUT_SHIFT - 1));
        assign shr = (sum + HALF) >>> OUT_SHIFT;
    end else begin : g_nornd
        assign shr = sum;
    end

    // ReLU on negative signed results, then clamp to WIDTH
    always_comb begin
        wide = 64'(shr);
        if ((RELU != 0) && SX && (wide < 0)) wide = '0;
        pix = WIDTH'(saturate(wide, SX, WIDTH));
    end

endmodule

// File: rtl/conv_accumulator.sv
// Sums K*K tap products per output pixel, post-processes the sum
// and presents the pixel with its map position on a valid/ready port.
module conv_accumulator
    import conv_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int kernel_size = KERNEL_SIZE,
    parameter int pic_size    = PIC_SIZE,
    parameter int SIGN        = 1,
    parameter int OUT_SHIFT   = 0,
    parameter int RELU        = 1,
    parameter int ACC_WIDTH   =
        WIDTH + $clog2(kernel_size * kernel_size) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     bias,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(pic_size-kernel_size+1)-1:0] out_row,
    output logic [$clog2(pic_size-kernel_size+1)-1:0] out_col,
    output logic                 out_last,
    output logic                 frame_done
);

    localparam int   N_TAPS = kernel_size * kernel_size;
    localparam int   N_DIM  = pic_size - kernel_size + 1;
    localparam int   TW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int   PW     = $clog2(N_DIM);
    localparam logic SX     = (SIGN != 0);

    state_t               state;
    state_t               state_nxt;
    logic [TW-1:0]        tap;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]     pix;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_tap;
    logic                 col_end;
    logic                 row_end;

    assign in_ext   = {{(ACC_WIDTH-WIDTH){SX & in_data[WIDTH-1]}},
                       in_data};
    assign acc_sum  = (tap == '0) ? in_ext : acc + in_ext;
    assign last_tap = (tap == TW'(N_TAPS - 1));
    assign col_end  = (out_col == PW'(N_DIM - 1));
    assign row_end  = (out_row == PW'(N_DIM - 1));

    assign in_ready  = (state == ACC) && !clear;
    assign out_valid = (state == EMIT);
    assign out_last  = row_end && col_end;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !clear;

    conv_sat_round #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .SIGN     (SIGN),
        .OUT_SHIFT(OUT_SHIFT),
        .RELU     (RELU)
    ) u_sat (
        .acc (acc_sum),
        .bias(bias),
        .pix (pix)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    // Collect taps until the last one, hold the pixel until taken
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC:     if (in_fire && last_tap) state_nxt = EMIT;
                EMIT:    if (out_fire) state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    // Tap counter and running partial sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap <= '0;
            acc <= '0;
        end else if (clear) begin
            tap <= '0;
            acc <= '0;
        end else if (in_fire) begin
            acc <= acc_sum;
            tap <= last_tap ? '0 : tap + TW'(1);
        end
    end

    // Capture the finished pixel on the final tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                out_data <= '0;
        else if (in_fire && last_tap) out_data <= pix;
    end

    // Output map position, advanced per accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row <= '0;
            out_col <= '0;
        end else if (clear) begin
            out_row <= '0;
            out_col <= '0;
        end else if (out_fire) begin
            if (col_end) begin
                out_col <= '0;
                out_row <= row_end ? '0 : out_row + PW'(1);
            end else begin
                out_col <= out_col + PW'(1);
            end
        end
    end

    // Pulse once after the final pixel of the map is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= out_fire && out_last;
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// Randomised bench for conv_accumulator: four parameter variants
// run in lockstep against a pixel-level model plus fixed vectors.
module tb_conv_accumulator;

    localparam int NV  = 4;
    localparam int DIM = 26;
    localparam int SH[NV]   = '{0, 0, 2, 0};
    localparam int RL[NV]   = '{1, 0, 1, 1};
    localparam int SG[NV]   = '{1, 1, 1, 0};

    logic       clk = 0;
    logic       rst_n = 0;
    logic       clear = 0;
    logic [7:0] bias = 0;
    logic [7:0] in_data = 0;
    logic       in_valid = 0;
    logic       out_ready = 0;

    logic       o_ready [NV];
    logic [7:0] o_data  [NV];
    logic       o_valid [NV];
    logic [4:0] o_row   [NV];
    logic [4:0] o_col   [NV];
    logic       o_last  [NV];
    logic       o_done  [NV];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_accumulator #(.SIGN(1), .OUT_SHIFT(0), .RELU(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bias(bias),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(o_ready[0]), .out_data(o_data[0]),
        .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_row(o_row[0]), .out_col(o_col[0]),
        .out_last(o_last[0]), .frame_done(o_done[0]));

    conv_accumulator #(.SIGN(1), .OUT_SHIFT(0), .RELU(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bias(bias),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(o_ready[1]), .out_data(o_data[1]),
        .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_row(o_row[1]), .out_col(o_col[1]),
        .out_last(o_last[1]), .frame_done(o_done[1]));

    conv_accumulator #(.SIGN(1), .OUT_SHIFT(2), .RELU(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bias(bias),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(o_ready[2]), .out_data(o_data[2]),
        .out_valid(o_valid[2]), .out_ready(out_ready),
        .out_row(o_row[2]), .out_col(o_col[2]),
        .out_last(o_last[2]), .frame_done(o_done[2]));

    conv_accumulator #(.SIGN(0), .OUT_SHIFT(0), .RELU(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bias(bias),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(o_ready[3]), .out_data(o_data[3]),
        .out_valid(o_valid[3]), .out_ready(out_ready),
        .out_row(o_row[3]), .out_col(o_col[3]),
        .out_last(o_last[3]), .frame_done(o_done[3]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d @%0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic int sx8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Pixel value from the arithmetic rules, on plain integers
    function automatic int ref_pix(input int s, input int sh,
                                   input int relu, input int sgn);
        int r;
        r = s;
        if (sh > 0) r = (r + (1 << (sh - 1))) >>> sh;
        if (relu != 0 && sgn != 0 && r < 0) r = 0;
        if (sgn != 0) begin
            if (r > 127) r = 127;
            if (r < -128) r = -128;
        end else begin
            if (r > 255) r = 255;
            if (r < 0) r = 0;
        end
        return r & 255;
    endfunction

    // Pixel-level model: collect nine taps, hold result until taken
    int         taps_q[$];
    logic       m_busy;
    int         m_pos;
    logic       m_done;
    int         m_exp [NV];
    int         ss, su;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_pos  <= 0;
            m_done <= 0;
            taps_q.delete();
        end else begin
            m_done <= 0;
            if (clear) begin
                taps_q.delete();
                m_busy <= 0;
                m_pos  <= 0;
            end else if (m_busy) begin
                if (out_ready) begin
                    m_busy <= 0;
                    if (m_pos == DIM * DIM - 1) begin
                        m_pos  <= 0;
                        m_done <= 1;
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
            end else if (in_valid) begin
                taps_q.push_back(int'(in_data));
                if (taps_q.size() == 9) begin
                    ss = sx8(int'(bias));
                    su = int'(bias);
                    foreach (taps_q[i]) begin
                        ss += sx8(taps_q[i]);
                        su += taps_q[i];
                    end
                    for (int k = 0; k < NV; k++)
                        m_exp[k] <= ref_pix(SG[k] != 0 ? ss : su,
                                            SH[k], RL[k], SG[k]);
                    m_busy <= 1;
                    taps_q.delete();
                end
            end
        end
    end

    // Every-cycle comparison of all variants against the model
    always @(negedge clk) begin
        for (int k = 0; k < NV; k++) begin
            chk($sformatf("d%0d_in_ready", k), int'(o_ready[k]),
                int'(!m_busy && !clear));
            chk($sformatf("d%0d_out_valid", k), int'(o_valid[k]),
                int'(m_busy));
            chk($sformatf("d%0d_frame_done", k), int'(o_done[k]),
                int'(m_done));
            if (m_busy) begin
                chk($sformatf("d%0d_out_data", k), int'(o_data[k]),
                    m_exp[k]);
                chk($sformatf("d%0d_out_row", k), int'(o_row[k]),
                    m_pos / DIM);
                chk($sformatf("d%0d_out_col", k), int'(o_col[k]),
                    m_pos % DIM);
                chk($sformatf("d%0d_out_last", k), int'(o_last[k]),
                    int'(m_pos == DIM * DIM - 1));
            end
        end
    end

    int fd_cnt = 0;
    always @(negedge clk) if (o_done[0]) fd_cnt++;

    int       g_data [NV];
    int       g_row, g_col, g_last;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] d, input logic [7:0] b);
        int n;
        n = 0;
        in_data  = d;
        bias     = b;
        in_valid = 1;
        @(negedge clk);
        while (!o_ready[0] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", int'(o_ready[0]), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic put9(input logic [7:0] d, input logic [7:0] b,
                        input bit gaps);
        for (int i = 0; i < 9; i++) begin
            put(d, b);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic get_pixel(input int delay, input bit pre);
        int n;
        n = 0;
        if (pre) out_ready = 1;
        @(negedge clk);
        while (!o_valid[0] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_valid", int'(o_valid[0]), 1);
        for (int k = 0; k < NV; k++) g_data[k] = int'(o_data[k]);
        g_row  = int'(o_row[0]);
        g_col  = int'(o_col[0]);
        g_last = int'(o_last[0]);
        if (!pre) begin
            repeat (delay) @(negedge clk);
            out_ready = 1;
        end
        @(posedge clk);
        #1;
        out_ready = 0;
    endtask

    task automatic expect4(input string t, input int e0, input int e1,
                           input int e2, input int e3);
        chk({t, "_d0"}, g_data[0], e0);
        chk({t, "_d1"}, g_data[1], e1);
        chk({t, "_d2"}, g_data[2], e2);
        chk({t, "_d3"}, g_data[3], e3);
    endtask

    int last_cnt;
    int snap_d, snap_r, snap_c;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(o_valid[0]), 0);
        chk("rst_in_ready", int'(o_ready[0]), 1);
        chk("rst_out_data", int'(o_data[0]), 0);
        chk("rst_out_row", int'(o_row[0]), 0);
        chk("rst_out_col", int'(o_col[0]), 0);
        chk("rst_out_last", int'(o_last[0]), 0);
        chk("rst_frame_done", int'(o_done[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int i = 1; i <= 9; i++) put(8'(i), 8'h00);
        @(negedge clk);
        chk("lat_out_valid", int'(o_valid[0]), 1);
        chk("lat_in_ready", int'(o_ready[0]), 0);
        snap_d = int'(o_data[0]);
        snap_r = int'(o_row[0]);
        snap_c = int'(o_col[0]);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("stall_data", int'(o_data[0]), snap_d);
            chk("stall_row", int'(o_row[0]), snap_r);
            chk("stall_col", int'(o_col[0]), snap_c);
            chk("stall_in_ready", int'(o_ready[0]), 0);
        end
        in_valid = 0;
        get_pixel(0, 0);
        expect4("seq1to9", 45, 45, 11, 45);
        chk("seq1to9_row", g_row, 0);
        chk("seq1to9_col", g_col, 0);

        put9(8'h7F, 8'h00, 1);
        get_pixel(1, 0);
        expect4("max7f", 8'h7F, 8'h7F, 8'h7F, 8'hFF);
        chk("max7f_col", g_col, 1);

        put9(8'hF0, 8'h00, 1);
        get_pixel(0, 1);
        expect4("negf0", 8'h00, 8'h80, 8'h00, 8'hFF);

        put9(8'h01, 8'hFB, 0);
        get_pixel(2, 0);
        expect4("bias", 8'h04, 8'h04, 8'h01, 8'hFF);

        for (int i = 0; i < 4; i++) put(8'($urandom), 8'h00);
        clear    = 1;
        in_valid = 1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        clear    = 0;
        in_valid = 0;
        put9(8'h02, 8'h00, 1);
        get_pixel(0, 0);
        expect4("clear", 18, 18, 5, 18);
        chk("clear_row", g_row, 0);
        chk("clear_col", g_col, 0);

        clear = 1;
        idle(1);
        clear = 0;
        last_cnt = 0;
        for (int p = 1; p <= DIM * DIM; p++) begin
            for (int t = 0; t < 9; t++) begin
                put(8'($urandom), 8'($urandom));
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            end
            get_pixel($urandom_range(0, 2), $urandom_range(0, 3) == 0);
            last_cnt += g_last;
            if (p == DIM * DIM) begin
                chk("frame_last", g_last, 1);
                chk("frame_last_row", g_row, 25);
                chk("frame_last_col", g_col, 25);
            end
        end
        idle(2);
        chk("frame_last_count", last_cnt, 1);
        chk("frame_done_count", fd_cnt, 1);
        put9(8'h01, 8'h00, 0);
        get_pixel(0, 0);
        chk("wrap_row", g_row, 0);
        chk("wrap_col", g_col, 0);
        chk("wrap_data", g_data[0], 9);

        put9(8'h05, 8'h00, 0);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("arst_out_valid", int'(o_valid[0]), 0);
        chk("arst_out_data", int'(o_data[0]), 0);
        chk("arst_in_ready", int'(o_ready[0]), 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 4; i++) put(8'h40, 8'h00);
        #2;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        put9(8'h03, 8'h00, 1);
        get_pixel(0, 0);
        expect4("arst_mid", 27, 27, 7, 27);
        chk("arst_mid_row", g_row, 0);
        chk("arst_mid_col", g_col, 0);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
